// File: rtl/fetch_decode_queue_pkg.sv
// Processor-wide constants shared by fetch, the fetch/decode buffer and decode.
// Also defines the entry format the buffer stores.
package fetch_decode_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    next_pc;
  } entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode buffer bus: the fetch/decode side drives the i* signals,
// and the buffer drives the o* signals.
interface fetch_decode_queue_if
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] iInstruction;
  logic [PC_W-1:0]    iNextPC;
  logic               iFetchValid;
  logic               iFlush;
  logic               iDecodeReady;
  logic [INSTR_W-1:0] oInstruction;
  logic [PC_W-1:0]    oNextPC;
  logic               oValid;
  logic               oFetchHalt;
  logic [PTR_W:0]     oCount;

  modport master (
    output iInstruction, iNextPC, iFetchValid, iFlush, iDecodeReady,
    input  oInstruction, oNextPC, oValid, oFetchHalt, oCount
  );

  modport slave (
    input  iInstruction, iNextPC, iFetchValid, iFlush, iDecodeReady,
    output oInstruction, oNextPC, oValid, oFetchHalt, oCount
  );

endinterface

// File: rtl/fetch_decode_queue.sv
// In-order instruction buffer between fetch and decode: registered pointers and
// count, combinational head read, flush discards everything buffered.
module fetch_decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter logic [fetch_decode_queue_pkg::INSTR_W-1:0] NOP_INSTR = fetch_decode_queue_pkg::NOP_INSTR
) (
  input logic                 iClk,
  input logic                 iReset,
  fetch_decode_queue_if.slave bus
);
  import fetch_decode_queue_pkg::*;

  localparam int unsigned    PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic   w_full;
  logic   w_valid;
  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  // Full is registered-state only, so a same-cycle pop never frees a slot for a push.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_valid = (r_count != '0);
  assign w_push  = bus.iFetchValid & ~w_full & ~bus.iFlush;
  assign w_pop   = w_valid & bus.iDecodeReady & ~bus.iFlush;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge iClk) begin
    if (iReset || bus.iFlush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{instr: bus.iInstruction, next_pc: bus.iNextPC};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.oValid       = w_valid;
  assign bus.oFetchHalt   = w_full;
  assign bus.oCount       = r_count;
  assign bus.oInstruction = w_valid ? w_head.instr   : NOP_INSTR;
  assign bus.oNextPC      = w_valid ? w_head.next_pc : '0;

  a_count_bound: assert property (@(posedge iClk) disable iff (iReset) r_count <= FULL_COUNT);
  a_no_push_full: assert property (@(posedge iClk) disable iff (iReset) w_push |-> !w_full);
  a_no_pop_empty: assert property (@(posedge iClk) disable iff (iReset) w_pop |-> w_valid);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios followed by random traffic,
// checked against a queue model of the buffer contents.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_decode_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(.DEPTH(DEPTH)) u_dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  int     n_tests    = 0;
  int     n_fail     = 0;
  int     n_accept   = 0;
  bit     chk_en     = 1'b0;
  bit     mon_popped = 1'b0;
  entry_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic dr, input logic rs);
    bus.iFetchValid  = fv;
    bus.iInstruction = ins;
    bus.iNextPC      = pc;
    bus.iFlush       = fl;
    bus.iDecodeReady = dr;
    rst              = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the buffer is an ordered list of accepted words, at most DEPTH long.
  always @(posedge clk) begin
    int occ;
    occ = exp_q.size() + int'(mon_popped);
    mon_popped = 1'b0;
    if (rst || bus.iFlush) exp_q.delete();
    else if (bus.iFetchValid && occ < DEPTH)
      exp_q.push_back('{instr: bus.iInstruction, next_pc: bus.iNextPC});
  end

  // Monitor: compares the visible head/state and consumes words decode accepts.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(bus.oCount), 32'(exp_q.size()));
      chk("valid", 32'(bus.oValid), 32'(exp_q.size() != 0));
      chk("halt", 32'(bus.oFetchHalt), 32'(exp_q.size() == DEPTH));
      if (exp_q.size() != 0) begin
        chk("head_instr", bus.oInstruction, exp_q[0].instr);
        chk("head_pc", bus.oNextPC, exp_q[0].next_pc);
        if (bus.iDecodeReady && !bus.iFlush && !rst) begin
          void'(exp_q.pop_front());
          mon_popped = 1'b1;
          n_accept++;
        end
      end else begin
        chk("empty_instr", bus.oInstruction, NOP_INSTR);
        chk("empty_pc", bus.oNextPC, 32'h0);
      end
    end
  end

  initial begin
    int base;
    drive(0, 0, 0, 0, 0, 1);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(bus.oValid), 32'h0);
    chk("rst_halt", 32'(bus.oFetchHalt), 32'h0);
    chk("rst_count", 32'(bus.oCount), 32'h0);
    chk("rst_instr", bus.oInstruction, 32'h0);
    step();

    // Fill to full; third word refused
    drive(1, 32'hA000_0001, 32'd1, 0, 0, 0); step();
    drive(1, 32'hA000_0002, 32'd2, 0, 0, 0); step();
    drive(1, 32'hA000_0003, 32'd3, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_count", 32'(bus.oCount), 32'd2);
    chk("full_halt", 32'(bus.oFetchHalt), 32'd1);
    chk("full_head", bus.oInstruction, 32'hA000_0001);
    step();

    // One pop from full
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pop_head", bus.oInstruction, 32'hA000_0002);
    chk("pop_count", 32'(bus.oCount), 32'd1);
    chk("pop_halt", 32'(bus.oFetchHalt), 32'd0);
    step();
    drive(0, 0, 0, 0, 1, 0); step(); step();

    // Steady stream with wraparound
    base = n_accept;
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'hB000_0000 + 32'(k), 32'(k + 100), 0, 1, 0);
      @(negedge clk);
      if (k > 0) chk("stream_count", 32'(bus.oCount), 32'd1);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 1, 0); step(); step();
    chk("stream_accepts", 32'(n_accept - base), 32'd8);

    // Flush with 2 buffered, alongside push and pop
    drive(1, 32'hC000_0001, 32'd11, 0, 0, 0); step();
    drive(1, 32'hC000_0002, 32'd12, 0, 0, 0); step();
    drive(1, 32'hC000_0003, 32'd13, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_valid", 32'(bus.oValid), 32'd0);
    chk("flush_count", 32'(bus.oCount), 32'd0);
    step();
    drive(1, 32'hD000_0001, 32'd21, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_flush_head", bus.oInstruction, 32'hD000_0001);
    step();

    // Reset mid-operation with a concurrent push
    drive(1, 32'hE000_0001, 32'd31, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_count", 32'(bus.oCount), 32'd0);
    chk("mid_rst_valid", 32'(bus.oValid), 32'd0);
    chk("mid_rst_instr", bus.oInstruction, NOP_INSTR);
    chk("mid_rst_pc", bus.oNextPC, 32'h0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 99) == 0));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
